register_write_arbiter: RTL and testbench
=========================================

Name: register_write_arbiter

Overview:
- Shares one Register_8B-style 8-bit register between NUM_REQ bus requesters (ALU result, memory load, immediate path, debug port).
- Round-robin arbitration, a valid/ack handshake, optional locked bursts, and a clear-request path.
- Drives the shared register's d, clock_enable and clear inputs.
- Sits between the datapath sources and the register.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, register data width.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester write valid.
- lock  in  NUM_REQ  per-requester burst hold, meaningful only while granted.
- wdata  in  NUM_REQ*DATA_W  packed write data; requester i owns bits [i*DATA_W +: DATA_W].
- clr_req  in  1  request to clear the shared register.
- grant  out  NUM_REQ  one-hot current owner; all zero when none.
- ack  out  NUM_REQ  one-cycle write-accepted strobe per requester.
- clr_ack  out  1  clear-accepted strobe.
- reg_d  out  DATA_W  to register d.
- reg_clock_enable  out  1  to register clock_enable.
- reg_clear  out  1  to register clear.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (clear_n low, asynchronous) forces the following, overriding any write in flight:
  - state IDLE; rr pointer 0.
  - grant, ack, clr_ack, reg_clock_enable, reg_clear and busy all 0.
  - reg_d 0.
- States: IDLE, WRITE, CLEAR.
- IDLE:
  - clr_req=1 takes priority over all req: next state CLEAR.
  - Otherwise, if any req is set: pick the first set req at or after the pointer, wrapping modulo NUM_REQ. grant <= onehot(pick); next state WRITE.
  - Otherwise stay in IDLE.
- WRITE, owner g:
  - reg_d = wdata slice g (combinational from the current wdata).
  - reg_clock_enable = req[g]; ack[g] = req[g].
  - The register captures on the edge that ends this cycle.
  - If req[g] and lock[g]: stay in WRITE (burst). The requester presents the next beat on the cycle after ack.
  - If req[g] and not lock[g]: last beat. Go to IDLE, clear grant, pointer <= (g+1) mod NUM_REQ.
  - If req[g]=0: no write and no ack (abort). Go to IDLE, pointer <= (g+1) mod NUM_REQ.
- CLEAR:
  - Lasts exactly one cycle: reg_clear=1, clr_ack=1, reg_clock_enable=0.
  - Then returns to IDLE; pointer unchanged.
- Latency: single write is req rise -> ack after 1 cycle; minimum 2 cycles per non-burst write. A burst sustains 1 beat/cycle.
- Handshake rules:
  - Requester holds req and wdata stable until ack.
  - After a non-locked ack, requester drops req in the following cycle; IDLE never samples a stale req.
  - req/lock of non-owners are ignored in WRITE.
- Simultaneous events:
  - clr_req during WRITE waits until IDLE.
  - Several req in IDLE: round-robin order only.
  - lock without req is ignored.
- grant is one-hot or zero at all times; ack is a subset of grant; reg_clock_enable and reg_clear are never both 1.

Decomposition:
- Shared package holds the state encodings as localparams (IDLE=2'd0, WRITE=2'd1, CLEAR=2'd2) and the NUM_REQ/DATA_W defaults.
- One sub-module, round_robin_picker: combinational, inputs req and pointer; outputs one-hot pick, index and any_req. Reusable by the later bus arbiter.

Test Plan:
- Reset mid-WRITE: owner 1 active, clear_n pulsed low -> all outputs 0 immediately, reg_clock_enable 0, register not written; after release, state IDLE and pointer 0.
- Single write: req=4'b0100, wdata slice2=8'hA5 -> next cycle grant=4'b0100, reg_d=8'hA5, reg_clock_enable=1, ack[2]=1; register holds 8'hA5; busy falls the cycle after.
- Round robin: req=4'b1111 held, each requester dropping req after its ack -> grant sequence 0,1,2,3; then req=4'b0011 re-raised -> 0,1.
- Locked burst: requester 3, lock=1, beats 8'h01,8'h02,8'h03, lock dropped on the third beat -> three consecutive ack[3] cycles, register ends 8'h03, pointer=0; requester 0 pending is granted next.
- Clear priority: clr_req=1 and req=4'b0001 together in IDLE -> CLEAR first (reg_clear=1, clr_ack=1, register 8'h00), then grant=4'b0001.
- Abort: requester 1 granted, drops req in the WRITE cycle -> no ack, no enable, IDLE, pointer=2.

Source files
------------

// File: rtl/register_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: state encodings and
// default sizing for the requester count and register width.
package register_write_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_WRITE = WRITE,
    S_CLEAR = CLEAR
  } arb_state_e;

endpackage

// File: rtl/register_write_arbiter_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo NUM_REQ. Shared with the bus arbiter.
module round_robin_picker
  import register_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  logic [PTR_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found        = 1'b1;
        o_idx          = w_cand;
        o_pick[w_cand] = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter in front of a shared register: grants one
// requester at a time, supports locked bursts and a one-cycle clear path.
module register_write_arbiter
  import register_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clock,
  input  logic                      clear_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic                      clr_req,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      clr_ack,
  output logic [DATA_W-1:0]         reg_d,
  output logic                      reg_clock_enable,
  output logic                      reg_clear,
  output logic                      busy
);

  localparam int               PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REQ - 1);

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_ptr;

  arb_state_e         w_state_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   w_ptr_inc;
  logic [NUM_REQ-1:0] w_pick;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any;

  round_robin_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_ptr_inc = (r_owner == LAST) ? '0 : r_owner + 1'b1;
  assign grant     = r_grant;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Register-side outputs are combinational so a reset or a dropped req
  // suppresses the write within the same cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_owner_nxt      = r_owner;
    w_ptr_nxt        = r_ptr;
    ack              = '0;
    clr_ack          = 1'b0;
    reg_d            = '0;
    reg_clock_enable = 1'b0;
    reg_clear        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
        end else if (w_any) begin
          w_state_nxt = S_WRITE;
          w_grant_nxt = w_pick;
          w_owner_nxt = w_idx;
        end
      end
      S_WRITE: begin
        reg_d            = wdata[r_owner*DATA_W +: DATA_W];
        reg_clock_enable = req[r_owner];
        ack[r_owner]     = req[r_owner];
        if (!(req[r_owner] && lock[r_owner])) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
        end
      end
      S_CLEAR: begin
        reg_clear   = 1'b1;
        clr_ack     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Scoreboard bench for register_write_arbiter: a round-robin reference model
// queues expected acks/clears, and a negedge monitor pops and compares them.
module tb_register_write_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 3;

  logic             clock   = 1'b0;
  logic             clear_n = 1'b0;
  logic [NR-1:0]    req     = '0;
  logic [NR-1:0]    lock    = '0;
  logic [NR*DW-1:0] wdata   = '0;
  logic             clr_req = 1'b0;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    ack;
  logic             clr_ack;
  logic [DW-1:0]    reg_d;
  logic             reg_clock_enable;
  logic             reg_clear;
  logic             busy;

  register_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clock            (clock),
    .clear_n          (clear_n),
    .req              (req),
    .lock             (lock),
    .wdata            (wdata),
    .clr_req          (clr_req),
    .grant            (grant),
    .ack              (ack),
    .clr_ack          (clr_ack),
    .reg_d            (reg_d),
    .reg_clock_enable (reg_clock_enable),
    .reg_clear        (reg_clear),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  // Stand-in for the shared 8-bit register downstream of the arbiter.
  logic [DW-1:0] tb_reg = '0;
  always @(posedge clock) begin
    if (reg_clear) tb_reg <= '0;
    else if (reg_clock_enable) tb_reg <= reg_d;
  end

  typedef struct {
    bit            is_clr;
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exq[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string nm, input longint unsigned act, input longint unsigned expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, expv, $time);
  endtask

  // Monitor: protocol invariants every cycle, plus scoreboard pops on strobes.
  int   mon_ai;
  exp_t mon_e;
  always @(negedge clock) begin
    if (clear_n) begin
      check("grant_onehot0", 64'($onehot0(grant)), 1);
      check("ack_in_grant", 64'(ack & ~grant), 0);
      check("ce_clear_excl", 64'(reg_clock_enable & reg_clear), 0);
      check("ce_matches_ack", 64'(reg_clock_enable), 64'(|ack));
      if (clr_ack) begin
        if (exq.size() == 0) check("unexpected_clr", 64'(clr_ack), 0);
        else begin
          mon_e = exq.pop_front();
          check("clr_order", 64'(mon_e.is_clr), 1);
          check("clr_reg_clear", 64'(reg_clear), 1);
        end
      end
      if (ack != '0) begin
        mon_ai = 0;
        for (int i = 0; i < NR; i++) if (ack[i]) mon_ai = i;
        if (exq.size() == 0) check("unexpected_ack", 64'(ack), 0);
        else begin
          mon_e = exq.pop_front();
          check("ack_kind", 64'(mon_e.is_clr), 0);
          check("ack_idx", 64'(mon_ai), 64'(mon_e.idx));
          check("ack_data", 64'(reg_d), 64'(mon_e.data));
        end
      end
    end
  end

  // Reference model state: round-robin pointer and last value written.
  int            m_ptr = 0;
  logic [DW-1:0] m_reg = '0;

  function automatic int rr_pick(input bit [NR-1:0] pend, input int ptr);
    for (int k = 0; k < NR; k++)
      if (pend[(ptr + k) % NR]) return (ptr + k) % NR;
    return 0;
  endfunction

  bit            ep_clr;
  bit [NR-1:0]   ep_mask;
  bit [NR-1:0]   ep_abort;
  int            ep_nb[NR];
  logic [DW-1:0] ep_dat[NR][MAXB];

  task automatic setup_ep(input bit c, input bit [NR-1:0] m, input bit [NR-1:0] a);
    ep_clr = c; ep_mask = m; ep_abort = a;
    for (int i = 0; i < NR; i++) begin
      ep_nb[i] = 1;
      for (int b = 0; b < MAXB; b++) ep_dat[i][b] = DW'($urandom);
    end
  endtask

  task automatic run_episode();
    bit [NR-1:0] pend;
    bit [NR-1:0] active;
    int          beat[NR];
    int          w;
    int          budget;
    logic [NR-1:0] s_ack;
    logic        s_clr;
    if (ep_clr) begin
      exq.push_back('{1'b1, 0, '0});
      m_reg = '0;
    end
    pend = ep_mask;
    while (pend != '0) begin
      w = rr_pick(pend, m_ptr);
      if (!ep_abort[w])
        for (int b = 0; b < ep_nb[w]; b++) begin
          exq.push_back('{1'b0, w, ep_dat[w][b]});
          m_reg = ep_dat[w][b];
        end
      m_ptr   = (w + 1) % NR;
      pend[w] = 1'b0;
    end
    active  = ep_mask;
    clr_req = ep_clr;
    for (int i = 0; i < NR; i++) begin
      beat[i] = 0;
      wdata[i*DW +: DW] = active[i] ? ep_dat[i][0] : DW'($urandom);
      req[i]  = active[i];
      lock[i] = active[i] && !ep_abort[i] && (ep_nb[i] > 1);
    end
    budget = 0;
    while ((active != '0 || clr_req) && budget < 200) begin
      @(negedge clock);
      s_ack = ack;
      s_clr = clr_ack;
      @(posedge clock);
      #1;
      budget++;
      if (s_clr) clr_req = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (active[i]) begin
          if (s_ack[i]) begin
            beat[i]++;
            if (beat[i] >= ep_nb[i]) begin
              req[i] = 1'b0; lock[i] = 1'b0; active[i] = 1'b0;
              wdata[i*DW +: DW] = DW'($urandom);
            end else begin
              wdata[i*DW +: DW] = ep_dat[i][beat[i]];
              lock[i] = (beat[i] < ep_nb[i] - 1);
            end
          end else if (ep_abort[i] && grant[i]) begin
            req[i] = 1'b0; lock[i] = 1'b0; active[i] = 1'b0;
          end
        end
      end
    end
    if (budget >= 200) begin
      check("episode_timeout", 64'(active), 0);
      req = '0; lock = '0; clr_req = 1'b0;
    end
    @(posedge clock);
    #1;
    check("idle_busy", 64'(busy), 0);
    check("idle_grant", 64'(grant), 0);
    check("queue_drained", 64'(exq.size()), 0);
    check("reg_value", 64'(tb_reg), 64'(m_reg));
    exq.delete();
  endtask

  logic [DW-1:0] saved;

  initial begin
    #1;
    check("reset_outputs", 64'({grant, ack, clr_ack, reg_clock_enable, reg_clear, busy, reg_d}), 0);
    #20;
    @(negedge clock) clear_n = 1'b1;
    @(posedge clock);
    #1;

    // Reset pulled while requester 1 owns the register.
    req = 4'b0010;
    wdata[1*DW +: DW] = 8'h5A;
    @(posedge clock);
    #1;
    check("rst_grant", 64'(grant), 64'(4'b0010));
    check("rst_ack_pre", 64'(ack), 64'(4'b0010));
    saved   = tb_reg;
    clear_n = 1'b0;
    #1;
    check("rst_outputs", 64'({grant, ack, clr_ack, reg_clock_enable, reg_clear, busy, reg_d}), 0);
    req = '0;
    @(posedge clock);
    #1;
    check("rst_no_write", 64'(tb_reg), 64'(saved));
    @(negedge clock) clear_n = 1'b1;
    m_ptr = 0;
    @(posedge clock);
    #1;
    check("rst_idle", 64'(busy), 0);

    setup_ep(1'b0, 4'b1111, 4'b0000); run_episode();
    setup_ep(1'b0, 4'b0011, 4'b0000); run_episode();
    setup_ep(1'b0, 4'b0100, 4'b0000); ep_dat[2][0] = 8'hA5; run_episode();
    check("single_reg_a5", 64'(tb_reg), 64'(8'hA5));
    setup_ep(1'b0, 4'b1001, 4'b0000);
    ep_nb[3] = 3; ep_dat[3][0] = 8'h01; ep_dat[3][1] = 8'h02; ep_dat[3][2] = 8'h03;
    ep_dat[0][0] = 8'h03;
    run_episode();
    setup_ep(1'b1, 4'b0001, 4'b0000); run_episode();
    setup_ep(1'b0, 4'b0010, 4'b0010); run_episode();
    setup_ep(1'b0, 4'b0111, 4'b0000); run_episode();

    for (int e = 0; e < 40; e++) begin
      setup_ep($urandom_range(0, 3) == 0, NR'($urandom_range(1, 15)), '0);
      for (int i = 0; i < NR; i++) begin
        ep_abort[i] = ($urandom_range(0, 4) == 0);
        ep_nb[i]    = $urandom_range(1, MAXB);
      end
      run_episode();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
